// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx_deser receiver.
// Holds the receive FSM state enum and the oversampling/frame constants.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Last tick index of a bit period that lasts n ticks.
    function automatic logic [TCNT_W-1:0] last_tick(input int n);
        return TCNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous 8-bit FIFO holding decoded receive bytes.
// Ports: clk_i, rst_ni, push_i/data_i (write), pop_i (read head),
//        full_o, empty_o, head_o (head byte, 0 while empty).
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the write.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign head_o = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x oversampling 8N1 UART receiver with byte FIFO.
// Ports: clock, resetn (async low), divisor (clocks per 1/16 bit),
//        rx (serial in), out_valid/out_data/out_ready (byte port),
//        frame_err, overrun (1-cycle pulses), busy (not IDLE).
// Build option UART_RX_PARITY_EN: 8E1 frames and a parity_err pulse.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [DIV_W-1:0] divisor,
    input  logic             rx,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    // Synchronizer resets to idle-high so no false start after reset.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic fall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    rx_state_e state_q, state_d;

    // Tick generator; held in reload while IDLE so each frame's
    // tick phase starts at its own start edge.
    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign div_m1 = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign tick   = (state_q != ST_IDLE) && (cnt_q == '0);

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            div_d = div_m1;
            cnt_d = div_m1;
        end else if (cnt_q == '0) begin
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              mid_end;
    logic              bit_end;

    assign mid_end = tick && (tcnt_q == last_tick(MID_SAMPLE));
    assign bit_end = tick && (tcnt_q == last_tick(OVERSAMPLE));

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                bcnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_end) begin
                    tcnt_d  = '0;
                    // Line back high mid start bit: a glitch.
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tcnt_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    tcnt_d  = '0;
                    par_d   = rx_s_q;
                    state_d = ST_STOP;
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    tcnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_q ^ (^shift_q);
`endif
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop       = out_valid & out_ready;
    assign overrun_d = push & fifo_full & ~pop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clock),
        .rst_ni (resetn),
        .push_i (push),
        .data_i (shift_q),
        .pop_i  (pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (out_data)
    );

    assign out_valid = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: randomized bench for uart_rx_deser with a
// frame-timing reference model and per-cycle output compare.
module tb_uart_rx_deser;

    localparam int DEPTH = 8;
    localparam int BIG   = 32'h3fffffff;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] divisor = 16'd1;
    logic        rx = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rx_deser #(
        .FIFO_DEPTH(DEPTH),
        .DIV_W(16)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .divisor  (divisor),
        .rx       (rx),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Reference model: byte queue plus scheduled frame outcomes.
    logic [7:0] mq[$];
    int         ev_t[$];
    logic [7:0] ev_b[$];
    int         ev_k[$];
    logic [7:0] popped[$];
    int         frm_start = 0;
    int         frm_end = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rdy_at = -10;
    bit         rnd_rdy = 0;
    bit         prev_pop = 0;
    logic [7:0] prev_d = 8'h00;
    bit         exp_fe;
    bit         exp_ov;

    function automatic logic [7:0] pget(input int i);
        if (i < popped.size()) return popped[i];
        return 8'hxx;
    endfunction

    always @(negedge clock) begin
        if (!resetn) begin
            mq.delete();
            ev_t.delete();
            ev_b.delete();
            ev_k.delete();
            prev_pop = 0;
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_data", 32'(out_data), 0);
            chk("rst_ferr", 32'(frame_err), 0);
            chk("rst_ovr", 32'(overrun), 0);
            chk("rst_busy", 32'(busy), 0);
        end else begin
            exp_fe = 0;
            exp_ov = 0;
            if (prev_pop) begin
                popped.push_back(prev_d);
                void'(mq.pop_front());
            end
            while (ev_t.size() > 0 && ev_t[0] <= cyc) begin
                if (ev_k[0] == 1) begin
                    if (mq.size() < DEPTH) mq.push_back(ev_b[0]);
                    else exp_ov = 1;
                end else begin
                    exp_fe = 1;
                end
                void'(ev_t.pop_front());
                void'(ev_b.pop_front());
                void'(ev_k.pop_front());
            end
            chk("valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("data", 32'(out_data),
                32'(mq.size() > 0 ? mq[0] : 8'h00));
            chk("frame_err", 32'(frame_err), 32'(exp_fe));
            chk("overrun", 32'(overrun), 32'(exp_ov));
            chk("busy", 32'(busy),
                32'(cyc >= frm_start && cyc < frm_end));
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_pop = (mq.size() > 0) && out_ready;
            prev_d = out_data;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        if (cyc == rdy_at) out_ready = 1'b1;
        else if (cyc == rdy_at + 1) out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drive one frame; the stop decision is due 2 sync cycles plus
    // 152 ticks after the edge where the start bit is first seen.
    task automatic send(input logic [7:0] b, input int d, input bit ok,
                        input bit scr, input bit pulse, input bit probe);
        int dd;
        int k;
        int p;
        logic bv;
        dd = (d == 0) ? 1 : d;
        step();
        divisor = 16'(d);
        k = cyc + 1;
        p = k + 2 + 152 * dd;
        frm_start = k + 2;
        frm_end = ok ? p : BIG;
        ev_t.push_back(p);
        ev_b.push_back(b);
        ev_k.push_back(ok ? 1 : 2);
        if (pulse) rdy_at = p - 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bv = 1'b0;
            else if (i == 9) bv = ok;
            else bv = b[i-1];
            rx = bv;
            if (scr && i == 4) divisor = 16'($urandom_range(0, 7));
            for (int c = 0; c < 16 * dd; c++) begin
                step();
                if (probe && cyc == p - 1) chk("lat_pre", 32'(out_valid), 0);
                if (probe && cyc == p) chk("lat_post", 32'(out_valid), 1);
            end
        end
        rdy_at = -10;
    endtask

    task automatic end_break(input int n);
        idle(n);
        rx = 1'b1;
        frm_end = cyc + 3;
        idle(4);
    endtask

    int k0;
    int fe0;
    int ov0;
    logic [7:0] rb;

    initial begin
        #1 resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(4);

        // Two bytes at divisor 1, latency pinned on the first.
        popped.delete();
        send(8'h55, 1, 1, 0, 0, 1);
        out_ready = 1'b1;
        idle(5);
        send(8'hA3, 1, 1, 0, 0, 0);
        idle(20);
        chk("t1_count", 32'(popped.size()), 2);
        chk("t1_b0", 32'(pget(0)), 32'h55);
        chk("t1_b1", 32'(pget(1)), 32'hA3);
        chk("t1_ferr", 32'(fe_cnt), 0);

        // Four-cycle glitch is rejected at mid start bit.
        popped.delete();
        step();
        divisor = 16'd1;
        rx = 1'b0;
        k0 = cyc + 1;
        frm_start = k0 + 2;
        frm_end = k0 + 10;
        idle(4);
        chk("gl_busy_hi", 32'(busy), 1);
        rx = 1'b1;
        idle(10);
        chk("gl_busy_lo", 32'(busy), 0);
        chk("gl_valid", 32'(out_valid), 0);
        chk("gl_nopush", 32'(popped.size()), 0);

        // Bad stop bit, BREAK until line high, then a good byte.
        fe0 = fe_cnt;
        send(8'h3C, 2, 0, 0, 0, 0);
        idle(40);
        chk("brk_busy", 32'(busy), 1);
        chk("brk_ferr", 32'(fe_cnt - fe0), 1);
        chk("brk_valid", 32'(out_valid), 0);
        end_break(0);
        chk("brk_idle", 32'(busy), 0);
        send(8'h81, 2, 1, 0, 0, 0);
        idle(10);
        chk("brk_count", 32'(popped.size()), 1);
        chk("brk_b0", 32'(pget(0)), 32'h81);

        // Nine bytes into a depth-8 FIFO with no reader.
        out_ready = 1'b0;
        idle(5);
        popped.delete();
        ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) send(8'(i), 1, 1, 0, 0, 0);
        chk("ov_none8", 32'(ov_cnt - ov0), 0);
        send(8'h08, 1, 1, 0, 0, 0);
        idle(3);
        chk("ov_once", 32'(ov_cnt - ov0), 1);
        out_ready = 1'b1;
        idle(20);
        chk("ov_count", 32'(popped.size()), 8);
        for (int i = 0; i < 8; i++) chk("ov_drain", 32'(pget(i)), 32'(i));

        // Full FIFO, pop in the cycle the ninth byte completes.
        out_ready = 1'b0;
        idle(3);
        popped.delete();
        ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) send(8'(i), 1, 1, 0, 0, 0);
        send(8'h08, 1, 1, 0, 1, 0);
        idle(3);
        chk("fp_noov", 32'(ov_cnt - ov0), 0);
        chk("fp_pop1", 32'(popped.size()), 1);
        chk("fp_b0", 32'(pget(0)), 32'h00);
        out_ready = 1'b1;
        idle(20);
        chk("fp_count", 32'(popped.size()), 9);
        for (int i = 1; i < 9; i++) chk("fp_drain", 32'(pget(i)), 32'(i));

        // Reset in the middle of DATA at divisor 3.
        out_ready = 1'b0;
        send(8'h11, 3, 1, 0, 0, 0);
        idle(3);
        chk("mr_valid_pre", 32'(out_valid), 1);
        step();
        divisor = 16'd3;
        rx = 1'b0;
        frm_start = cyc + 3;
        frm_end = BIG;
        idle(16 * 3 * 3);
        chk("mr_busy_pre", 32'(busy), 1);
        resetn = 1'b0;
        rx = 1'b1;
        frm_start = 0;
        frm_end = 0;
        #1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_data", 32'(out_data), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ferr", 32'(frame_err), 0);
        chk("mr_ovr", 32'(overrun), 0);
        idle(3);
        resetn = 1'b1;
        idle(4);
        popped.delete();
        out_ready = 1'b1;
        send(8'hE7, 3, 1, 0, 0, 0);
        idle(10);
        chk("mr_count", 32'(popped.size()), 1);
        chk("mr_b0", 32'(pget(0)), 32'hE7);

        // Random bytes, divisors, gaps, bad stops and reader stalls.
        rnd_rdy = 1;
        for (int i = 0; i < 25; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 6) == 0) begin
                send(rb, $urandom_range(0, 4), 0, 1, 0, 0);
                end_break($urandom_range(5, 40));
            end else begin
                send(rb, $urandom_range(0, 4), 1, 1, 0, 0);
            end
            idle($urandom_range(1, 30));
        end
        rnd_rdy = 0;
        out_ready = 1'b1;
        idle(30);
        chk("rnd_empty", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-parallel receiver that consumes the 8N1 stream driven on the UART16550 `uart_tx` pin and returns decoded bytes to the SoC simulation side. It sits directly downstream of the APB UART wrapper. It oversamples the line at 16x, validates start and stop bits, and buffers decoded bytes in a small FIFO behind a valid/ready port. Benches, loopback tests and the console bridge use it in place of an external terminal.

## Interface
- `FIFO_DEPTH`, default 8: byte buffer depth; power of two, minimum 2.
- `DIV_W`, default 16: width of the divisor input.
- `clock`  in  1: single clock; every flop is on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset. Release is synchronous to `clock`.
- `divisor`  in  DIV_W: `clock` cycles per 1/16 bit. The value 0 is treated as 1. Sampled only in IDLE.
- `rx`  in  1: serial line, idle high. Connected to `uart_tx`.
- `out_valid`  out  1: FIFO is non-empty.
- `out_data`  out  8: byte at the FIFO head.
- `out_ready`  in  1: consumer accepts the head byte.
- `frame_err`  out  1: one-cycle pulse when a bad stop bit is seen.
- `overrun`  out  1: one-cycle pulse when a byte is dropped because the FIFO is full.
- `busy`  out  1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Its reset value is 1, so the synchronized line (`rx_s`) reads idle after reset.
- Tick generator:
  - Down-counter loaded with `divisor-1`.
  - Emits `tick` when the count is 0, then reloads.
  - Forced to reload whenever the FSM is in IDLE, so every frame is phase-aligned to its start edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START on a falling edge of `rx_s`. The bit counter clears.
  - START: after 8 ticks (mid start bit), `rx_s`=0 -> DATA. `rx_s`=1 -> IDLE (glitch rejected, nothing reported).
  - DATA: every 16 ticks, shift `rx_s` into the MSB of the shift register (LSB-first on the wire). After the 8th bit -> STOP.
  - STOP: after 16 ticks, sample the line.
    - `rx_s`=1: push the byte and go to IDLE.
    - `rx_s`=0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE.
- FIFO rules:
  - Push is attempted in the same cycle as the STOP decision.
  - If full at push: the byte is dropped, `overrun` pulses, and FIFO contents are unchanged.
  - Pop happens when `out_valid & out_ready`.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds and `overrun` does not fire.
- Pointers are log2(FIFO_DEPTH)+1 bits wide. Full and empty are decided by the extra MSB, and the pointers wrap naturally.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE, FIFO empty.
- Latency from a valid stop-bit sample to `out_valid` rising: 1 cycle, because `out_valid` is registered from the pointers.
- `out_data` is stable while `out_valid` is high and `out_ready` is low.
- Frame duration:
  - Start edge to STOP decision: 8 + 16×9 = 152 ticks.
  - The synchronizer adds 2 cycles of line delay.
- Reset asserted mid-frame: return to IDLE immediately, flush the FIFO, and drop any partial byte.
- Changing `divisor` outside IDLE has no effect until the next frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame becomes 8E1, with a PARITY state between DATA and STOP (16 ticks).
  - Adds output `parity_err` (1 bit, reset 0). It pulses in the STOP-decision cycle when the received bit differs from the XOR of the data bits.
  - A byte with a parity error is still pushed into the FIFO.
- Not defined: 8N1 only, no PARITY state, no `parity_err` port.

## Structure
- Package `uart_rx_pkg` holds:
  - the FSM state enum;
  - `OVERSAMPLE`=16, `MID_SAMPLE`=8, `DATA_BITS`=8.
- Sub-module `uart_rx_fifo` is a synchronous FIFO parameterized by depth with an 8-bit width. It exposes `push`, `pop`, `full`, `empty` and `head`.

## Test plan
- `divisor`=1, send 0x55 then 0xA3 in 8N1 -> `out_data` reads 0x55 then 0xA3. `frame_err`=0 throughout.
- Pull `rx` low for 4 cycles at `divisor`=1 -> glitch rejected. No push, FSM back in IDLE, `busy` low after START.
- Send 0x3C with stop bit held low -> one `frame_err` pulse and no push. The FSM stays in BREAK until `rx` goes high. A following 0x81 is received correctly.
- Hold `out_ready`=0 and send 9 bytes (0x00–0x08) with `FIFO_DEPTH`=8 -> `overrun` pulses once on byte 0x08. Draining yields 0x00–0x07.
- With the FIFO full, assert `out_ready` in the cycle the 9th byte completes -> no `overrun`, and the FIFO holds 0x01–0x08.
- Assert `resetn` low mid-DATA at `divisor`=3 -> outputs return to reset values immediately and the FIFO is empty. Sending 0xE7 afterward decodes correctly.
